// File: rtl/sparc_exu_ecl_errlog.sv
// sparc_exu_ecl_errlog
// Captures ECC error records reported in M, registers them into W, and
// buffers them in a small FIFO that the IFU error logger drains one record
// at a time.
//
// When the FIFO is full and nothing retires, UE records take priority over
// CE records: an incoming UE replaces a CE sitting in the youngest entry.
// Any information that is lost sets the me bit on the youngest entry and
// bumps a saturating overflow counter.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   ecc_ce_m, ecc_ue_m  correctable / uncorrectable error flags in M
//   err_reg_m           {window/gl[2:0], rs[4:0]} of the errored register
//   err_synd_m          {synd_7, synd[6:0]}
//   tid_m               thread id of the M instruction
//   flush_m             kills the M instruction, so nothing is captured
//   log_ack             IFU accepts the head record
//   log_vld, log_ue, log_tid, log_reg, log_synd, log_me
//                       head record; data fields read 0 when empty
//   errlog_full         occupancy equals DEPTH
//   errlog_cnt          occupancy
//   ovfl_cnt            saturating count of dropped or overwritten records
//
// Handshake: log_vld means a head record is present. The head retires on
// any rising clk edge where log_vld and log_ack are both 1. While log_vld=1
// and log_ack=0 the head holds. The only exception is a full-FIFO overflow
// that lands on the head (DEPTH entries, head == youngest).
module sparc_exu_ecl_errlog #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ecc_ce_m,
  input  logic             ecc_ue_m,
  input  logic [7:0]       err_reg_m,
  input  logic [7:0]       err_synd_m,
  input  logic [1:0]       tid_m,
  input  logic             flush_m,
  input  logic             log_ack,
  output logic             log_vld,
  output logic             log_ue,
  output logic [1:0]       log_tid,
  output logic [7:0]       log_reg,
  output logic [7:0]       log_synd,
  output logic             log_me,
  output logic             errlog_full,
  output logic [CNT_W-1:0] errlog_cnt,
  output logic [7:0]       ovfl_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // W-stage record
  logic       vld_w;
  logic       ue_w;
  logic [1:0] tid_w;
  logic [7:0] reg_w;
  logic [7:0] synd_w;

  // FIFO storage
  logic       ent_ue   [DEPTH];
  logic [1:0] ent_tid  [DEPTH];
  logic [7:0] ent_reg  [DEPTH];
  logic [7:0] ent_synd [DEPTH];
  logic       ent_me   [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] yptr;
  logic [CNT_W-1:0] cnt;

  logic capture;
  logic pop;
  logic push;
  logic ovfl_ev;
  logic overwrite;

  assign capture   = (ecc_ce_m | ecc_ue_m) & ~flush_m;
  assign pop       = log_vld & log_ack;
  assign push      = vld_w & ((cnt != FULL_CNT) | pop);
  assign ovfl_ev   = vld_w & (cnt == FULL_CNT) & ~pop;
  // youngest entry sits just behind the write pointer
  assign yptr      = wptr - 1'b1;
  // a UE may only displace a CE; UE-over-UE just drops the newcomer
  assign overwrite = ovfl_ev & ue_w & ~ent_ue[yptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_w    <= 1'b0;
      ue_w     <= 1'b0;
      tid_w    <= '0;
      reg_w    <= '0;
      synd_w   <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      ovfl_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_ue[i]   <= 1'b0;
        ent_tid[i]  <= '0;
        ent_reg[i]  <= '0;
        ent_synd[i] <= '0;
        ent_me[i]   <= 1'b0;
      end
    end else begin
      vld_w <= capture;
      if (capture) begin
        ue_w   <= ecc_ue_m;
        tid_w  <= tid_m;
        reg_w  <= err_reg_m;
        synd_w <= err_synd_m;
      end

      if (push) begin
        ent_ue[wptr]   <= ue_w;
        ent_tid[wptr]  <= tid_w;
        ent_reg[wptr]  <= reg_w;
        ent_synd[wptr] <= synd_w;
        ent_me[wptr]   <= 1'b0;
        wptr           <= wptr + 1'b1;
      end else if (ovfl_ev) begin
        if (overwrite) begin
          ent_ue[yptr]   <= 1'b1;
          ent_tid[yptr]  <= tid_w;
          ent_reg[yptr]  <= reg_w;
          ent_synd[yptr] <= synd_w;
        end
        ent_me[yptr] <= 1'b1;
        if (ovfl_cnt != 8'hFF) ovfl_cnt <= ovfl_cnt + 8'd1;
      end

      if (pop) rptr <= rptr + 1'b1;

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head record, masked to 0 when the FIFO is empty so stale storage
  // never leaks onto the bus.
  assign log_vld     = (cnt != '0);
  assign log_ue      = log_vld & ent_ue[rptr];
  assign log_tid     = log_vld ? ent_tid[rptr]  : '0;
  assign log_reg     = log_vld ? ent_reg[rptr]  : '0;
  assign log_synd    = log_vld ? ent_synd[rptr] : '0;
  assign log_me      = log_vld & ent_me[rptr];
  assign errlog_full = (cnt == FULL_CNT);
  assign errlog_cnt  = cnt;

endmodule

// File: tb/tb_sparc_exu_ecl_errlog.sv
module tb_sparc_exu_ecl_errlog;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ecc_ce_m, ecc_ue_m, flush_m, log_ack;
  logic [7:0]       err_reg_m, err_synd_m;
  logic [1:0]       tid_m;
  logic             log_vld, log_ue, log_me, errlog_full;
  logic [1:0]       log_tid;
  logic [7:0]       log_reg, log_synd, ovfl_cnt;
  logic [CNT_W-1:0] errlog_cnt;

  int total = 0;
  int bad   = 0;

  sparc_exu_ecl_errlog #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ecc_ce_m(ecc_ce_m), .ecc_ue_m(ecc_ue_m),
    .err_reg_m(err_reg_m), .err_synd_m(err_synd_m),
    .tid_m(tid_m), .flush_m(flush_m), .log_ack(log_ack),
    .log_vld(log_vld), .log_ue(log_ue), .log_tid(log_tid),
    .log_reg(log_reg), .log_synd(log_synd), .log_me(log_me),
    .errlog_full(errlog_full), .errlog_cnt(errlog_cnt), .ovfl_cnt(ovfl_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a record queue plus one pending W record.
  typedef struct packed {
    logic       ue;
    logic [1:0] tid;
    logic [7:0] rg;
    logic [7:0] sy;
    logic       me;
  } rec_t;

  rec_t mq[$];
  rec_t mw;
  logic mw_vld = 1'b0;
  int   movf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    rec_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("log_vld",  32'(log_vld),     32'(mq.size() != 0));
    chk("log_ue",   32'(log_ue),      32'(h.ue));
    chk("log_tid",  32'(log_tid),     32'(h.tid));
    chk("log_reg",  32'(log_reg),     32'(h.rg));
    chk("log_synd", 32'(log_synd),    32'(h.sy));
    chk("log_me",   32'(log_me),      32'(h.me));
    chk("full",     32'(errlog_full), 32'(mq.size() == DEPTH));
    chk("cnt",      32'(errlog_cnt),  32'(mq.size()));
    chk("ovfl_cnt", 32'(ovfl_cnt),    32'(movf));
  endtask

  // Model the effect of one clock edge from the inputs in force before it.
  task automatic model_edge();
    bit   pop;
    rec_t t;
    if (rst) begin
      mq.delete();
      mw_vld = 1'b0;
      movf   = 0;
      return;
    end
    pop = (mq.size() != 0) && log_ack;
    if (mw_vld) begin
      if (mq.size() < DEPTH || pop) begin
        t = mw; t.me = 1'b0;
        mq.push_back(t);
      end else begin
        t = mq[mq.size()-1];
        if (mw.ue && !t.ue) t = mw;
        t.me = 1'b1;
        mq[mq.size()-1] = t;
        if (movf < 255) movf++;
      end
    end
    if (pop) void'(mq.pop_front());
    mw_vld = (ecc_ce_m | ecc_ue_m) & ~flush_m;
    if (mw_vld) begin
      mw.ue  = ecc_ue_m;
      mw.tid = tid_m;
      mw.rg  = err_reg_m;
      mw.sy  = err_synd_m;
      mw.me  = 1'b0;
    end
  endtask

  // One cycle: drive inputs away from the edge, clock, model, check.
  task automatic cyc(input logic ce, input logic ue, input logic [7:0] rg,
                     input logic [7:0] sy, input logic [1:0] tid,
                     input logic fl, input logic ack, input logic r);
    ecc_ce_m = ce; ecc_ue_m = ue; err_reg_m = rg; err_synd_m = sy;
    tid_m = tid; flush_m = fl; log_ack = ack; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, ack, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_ce(input logic [7:0] rg, input logic ack);
    cyc(1'b1, 1'b0, rg, rg ^ 8'h5A, 2'(rg), 1'b0, ack, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_reg[4];
    logic       exp_me[4];

    // Reset
    do_reset();
    do_reset();
    chk("rst_vld", 32'(log_vld), 32'd0);
    chk("rst_ovf", 32'(ovfl_cnt), 32'd0);

    // Single CE: cycle 0 capture, visible at cycle 2, ack at cycle 5
    cyc(1'b1, 1'b0, 8'h2B, 8'h95, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("ce_c1_vld", 32'(log_vld), 32'd0);
    idle(1'b0);
    chk("ce_vld",  32'(log_vld),  32'd1);
    chk("ce_ue",   32'(log_ue),   32'd0);
    chk("ce_reg",  32'(log_reg),  32'h2B);
    chk("ce_synd", 32'(log_synd), 32'h95);
    chk("ce_tid",  32'(log_tid),  32'd2);
    chk("ce_me",   32'(log_me),   32'd0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("ce_ack_vld", 32'(log_vld),    32'd0);
    chk("ce_ack_cnt", 32'(errlog_cnt), 32'd0);

    // Flush suppresses capture
    cyc(1'b0, 1'b1, 8'h11, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("flush_vld", 32'(log_vld),  32'd0);
    chk("flush_ovf", 32'(ovfl_cnt), 32'd0);

    // Overflow drop
    for (int i = 1; i <= 5; i++) push_ce(8'(i), 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("drop_full", 32'(errlog_full), 32'd1);
    chk("drop_cnt",  32'(errlog_cnt),  32'd4);
    chk("drop_ovf",  32'(ovfl_cnt),    32'd1);
    exp_reg = '{8'd1, 8'd2, 8'd3, 8'd4};
    exp_me  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      chk("drop_order", 32'(log_reg), 32'(exp_reg[i]));
      chk("drop_me",    32'(log_me),  32'(exp_me[i]));
      idle(1'b1);
    end
    chk("drop_empty", 32'(log_vld), 32'd0);

    // UE overwrite of youngest CE
    do_reset();
    for (int i = 1; i <= 4; i++) push_ce(8'(i), 1'b0);
    cyc(1'b0, 1'b1, 8'h09, 8'hC3, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("ow_ovf", 32'(ovfl_cnt), 32'd1);
    exp_reg = '{8'd1, 8'd2, 8'd3, 8'd9};
    for (int i = 0; i < 4; i++) begin
      chk("ow_order", 32'(log_reg), 32'(exp_reg[i]));
      chk("ow_ue",    32'(log_ue),  32'(i == 3));
      chk("ow_me",    32'(log_me),  32'(i == 3));
      idle(1'b1);
    end

    // Simultaneous push and pop when full
    do_reset();
    for (int i = 1; i <= 4; i++) push_ce(8'(i), 1'b0);
    push_ce(8'h07, 1'b0);   // reg 7 lands in W; FIFO full after this edge
    idle(1'b1);             // pop reg 1 and push reg 7 together
    chk("pp_cnt",  32'(errlog_cnt), 32'd4);
    chk("pp_ovf",  32'(ovfl_cnt),   32'd0);
    chk("pp_head", 32'(log_reg),    32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("pp_me", 32'(log_me), 32'd0);
      idle(1'b1);
    end

    // Reset mid-operation, then saturation
    for (int i = 1; i <= 3; i++) push_ce(8'(i), 1'b0);
    idle(1'b0);
    chk("mid_cnt3", 32'(errlog_cnt), 32'd3);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("mid_vld", 32'(log_vld),    32'd0);
    chk("mid_cnt", 32'(errlog_cnt), 32'd0);
    chk("mid_ovf", 32'(ovfl_cnt),   32'd0);
    for (int i = 0; i < 304; i++) push_ce(8'(i), 1'b0);
    idle(1'b0);
    chk("sat_ovf", 32'(ovfl_cnt), 32'd255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sparc_exu_ecl_errlog.md
Name: sparc_exu_ecl_errlog

Overview:
- Downstream consumer of the EXU ECC control stage's M-stage error outputs: CE/UE flags, error register index and syndrome bit 7.
- Registers each non-flushed error record into W, then buffers it in a small FIFO.
- Presents records one at a time to the IFU error-logging logic over a valid/ack handshake.
- When the FIFO is full, preserves UE records over CE records and flags lost information with a multiple-error (ME) bit.

Parameters:
- DEPTH, 4, number of FIFO record entries (power of 2, at least 2)
- CNT_W, 3, width of the occupancy count; equals log2(DEPTH)+1

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- ecc_ce_m  in  1  correctable error reported in M
- ecc_ue_m  in  1  uncorrectable error reported in M
- err_reg_m  in  8  {window/gl[2:0], rs[4:0]} of the errored register
- err_synd_m  in  8  {synd_7, synd[6:0]}
- tid_m  in  2  thread id of the M instruction
- flush_m  in  1  kill the M instruction; suppresses capture
- log_ack  in  1  IFU accepts the head record
- log_vld  out  1  head record valid
- log_ue  out  1  head record is UE (0 means CE)
- log_tid  out  2  head record thread
- log_reg  out  8  head record register index
- log_synd  out  8  head record syndrome
- log_me  out  1  at least one error was dropped or overwritten after this record was captured
- errlog_full  out  1  FIFO occupancy equals DEPTH
- errlog_cnt  out  CNT_W  FIFO occupancy
- ovfl_cnt  out  8  saturating count of dropped or overwritten records

Behaviour:
- Reset
  - Applies on the clk edge with rst=1: W register invalid, FIFO empty, pointers 0, ovfl_cnt 0.
  - All outputs read 0 after reset; log_* data fields read 0 when empty.
  - Reset mid-handshake discards all records; no ack is required afterwards.
- M to W capture (flopped)
  - vld_w <= (ecc_ce_m | ecc_ue_m) & ~flush_m.
  - ue_w <= ecc_ue_m. If ce and ue are both high, the record is treated as UE.
  - tid, reg and synd are flopped alongside.
  - Data flops load only when capture occurs; otherwise they hold.
- FIFO push at W
  - pop = log_vld & log_ack.
  - Push when vld_w and (cnt < DEPTH, or pop this cycle); a new entry is written at the tail with me=0.
  - Full with no pop, incoming UE, youngest entry is CE: overwrite the youngest entry with the UE record and set me=1 on it. Increment ovfl_cnt.
  - Full with no pop, any other case: drop the incoming record, set me=1 on the youngest entry, increment ovfl_cnt.
  - ovfl_cnt saturates at 255 and is cleared only by reset.
- Pop
  - On a pop the head entry retires at the edge and the read pointer increments modulo DEPTH.
  - Push and pop in the same cycle: cnt is unchanged, and both pointers advance.
  - Push into an empty FIFO while log_ack=1: the record is not bypassed. log_vld rises the next cycle.
- Outputs
  - log_* are driven combinationally from the head entry (registered storage, no bypass).
  - log_vld = (cnt != 0).
  - errlog_full = (cnt == DEPTH).
- Latency: an error at M in cycle N reaches W at N+1 and appears as log_vld=1 at N+2 when the FIFO was empty.
- Ordering: strict FIFO across all threads; there is no per-thread reordering.
- Stability: while log_vld=1 and log_ack=0, all log_* outputs hold stable. They change only at a pop, or when an overflow sets the me bit or overwrites the youngest entry, and that entry is the head only when DEPTH occupancy coincides with it.

Test Plan:
- Single CE:
  - Stimulus: ecc_ce_m=1, err_reg_m=8'h2B, err_synd_m=8'h95, tid_m=2 at cycle 0; log_ack held 0.
  - Required: log_vld=1 at cycle 2 with log_ue=0, log_reg=8'h2B, log_synd=8'h95, log_tid=2, log_me=0. Ack at cycle 5 gives log_vld=0 at cycle 6 and cnt=0.
- Flush:
  - Stimulus: ecc_ue_m=1 with flush_m=1.
  - Required: no record; log_vld stays 0 and ovfl_cnt stays 0.
- Overflow drop:
  - Stimulus: push 4 CEs (reg 1..4) with no ack, then a 5th CE (reg 5).
  - Required: errlog_full=1, cnt=4, the entry with reg 4 has me=1, ovfl_cnt=1. Draining yields regs 1,2,3,4 in order, with log_me=1 only on reg 4.
- UE overwrite:
  - Stimulus: FIFO full of CEs (regs 1..4), then a UE with reg 9.
  - Required: the youngest entry becomes UE, reg 9, me=1; ovfl_cnt=1. Drain order is 1,2,3,9.
- Simultaneous push and pop when full:
  - Stimulus: cnt=4, log_ack=1 while vld_w=1.
  - Required: head retires, new record accepted, cnt stays 4, no me bit set, ovfl_cnt unchanged.
- Reset mid-operation and saturation:
  - Stimulus: assert rst with cnt=3 and log_vld=1.
  - Required: the next cycle gives log_vld=0, cnt=0, ovfl_cnt=0.
  - Then, with ack held 0, apply 300 overflow events: ovfl_cnt reads 255.
